multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32 datapath. Decodes the opcode held in the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback steps, and drives all datapath enables and mux selects. Produces the 2-bit `alu_op` consumed by the ALU control decoder: `00` = add, `01` = subtract/compare, `10` = R-type funct decode. Sits between the instruction register and the datapath; it stalls on a single shared memory port through a ready handshake.

---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for the multicycle RV32 datapath. Decodes
//                the instruction-register opcode and steps each instruction
//                through fetch/decode/execute/memory/writeback. It drives all
//                datapath enables and mux selects. It stalls on the single
//                shared memory port through the mem_ready_i handshake.
//  Options     : ILLEGAL_TRAP_EN - when defined, an unsupported opcode traps
//                into a HALT state that only rst leaves. When undefined, an
//                unsupported opcode retires as a counted NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode_i,
   input  logic             alu_zero_i,
   input  logic             mem_ready_i,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             i_or_d_o,
   output logic             ir_write_o,
   output logic             pc_en_o,
   output logic             pc_source_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic             instr_done_o,
   output logic [CNT_W-1:0] retired_count_o,
   output logic             illegal_o
);

   // Supported major opcodes
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   // ALU operation codes for the ALU control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand selects
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9
`ifdef ILLEGAL_TRAP_EN
      ,
      HALT      = 4'd10
`endif
   } state_t;

   state_t           state_q, state_d;
   // Load/store direction captured in DECODE so MEM_ADDR ignores later opcode changes
   logic             is_store_q, is_store_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;

   // State, opcode latch, sticky illegal flag and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         illegal_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         illegal_q  <= illegal_d;
         count_q    <= count_d;
      end
   end

   // Next-state and Moore output decode; pc_en/ir_write/instr_done also see inputs
   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      illegal_d    = illegal_q;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      ir_write_o   = 1'b0;
      pc_en_o      = 1'b0;
      pc_source_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_REG;
      alu_op_o     = ALUOP_ADD;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      instr_done_o = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         // Read instruction at PC while PC+4 is computed; both land on mem_ready
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            ir_write_o  = mem_ready_i;
            pc_en_o     = mem_ready_i;
            if (mem_ready_i) begin
               state_d = DECODE;
            end
         end

         // Branch target (PC + imm) is computed speculatively into ALUOut
         DECODE: begin
            alu_src_b_o = SRCB_IMM;
            is_store_d  = (opcode_i == OP_SW);
            case (opcode_i)
               OP_LW,
               OP_SW:   state_d = MEM_ADDR;
               OP_RTYP: state_d = EXECUTE;
               OP_BEQ:  state_d = BRANCH;
               default: begin
                  illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                  state_d   = HALT;
`else
                  instr_done_o = 1'b1;
                  state_d      = FETCH;
`endif
               end
            endcase
         end

         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            state_d     = is_store_q ? MEM_WRITE : MEM_READ;
         end

         MEM_READ: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
            if (mem_ready_i) begin
               state_d = MEM_WB;
            end
         end

         MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            instr_done_o = 1'b1;
            state_d      = FETCH;
         end

         // A store retires in the cycle its write is accepted
         MEM_WRITE: begin
            mem_write_o  = 1'b1;
            i_or_d_o     = 1'b1;
            instr_done_o = mem_ready_i;
            if (mem_ready_i) begin
               state_d = FETCH;
            end
         end

         EXECUTE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_FUNCT;
            state_d     = ALU_WB;
         end

         ALU_WB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
            state_d      = FETCH;
         end

         // Compare A-B; on equality load PC from the target held in ALUOut
         BRANCH: begin
            alu_src_a_o  = 1'b1;
            alu_op_o     = ALUOP_SUB;
            pc_source_o  = 1'b1;
            pc_en_o      = alu_zero_i;
            instr_done_o = 1'b1;
            state_d      = FETCH;
         end

`ifdef ILLEGAL_TRAP_EN
         HALT: begin
            state_d = HALT;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Retired-instruction counter wraps naturally modulo 2^CNT_W
   always_comb begin
      count_d = count_q;
      if (instr_done_o) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   assign retired_count_o = count_q;
   assign illegal_o       = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control. A
//                second instance with a 2-bit counter follows the same
//                stimulus to exercise counter wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_ILL  = 7'b0010011;

   // Output vector order:
   // mem_read mem_write i_or_d ir_write pc_en pc_source alu_src_a | alu_src_b | alu_op | reg_write mem_to_reg instr_done
   localparam logic [13:0] V_ZERO    = 14'b0000000_00_00_000;
   localparam logic [13:0] V_FETCH_R = 14'b1001100_01_00_000;
   localparam logic [13:0] V_FETCH_W = 14'b1000000_01_00_000;
   localparam logic [13:0] V_DECODE  = 14'b0000000_10_00_000;
   localparam logic [13:0] V_DEC_ILL = 14'b0000000_10_00_001;
   localparam logic [13:0] V_MADDR   = 14'b0000001_10_00_000;
   localparam logic [13:0] V_MRD     = 14'b1010000_00_00_000;
   localparam logic [13:0] V_MWB     = 14'b0000000_00_00_111;
   localparam logic [13:0] V_MWR_R   = 14'b0110000_00_00_001;
   localparam logic [13:0] V_MWR_W   = 14'b0110000_00_00_000;
   localparam logic [13:0] V_EXEC    = 14'b0000001_00_10_000;
   localparam logic [13:0] V_AWB     = 14'b0000000_00_00_101;
   localparam logic [13:0] V_BR_Z1   = 14'b0000111_00_01_001;
   localparam logic [13:0] V_BR_Z0   = 14'b0000011_00_01_001;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        alu_zero;
   logic        mem_ready;
   logic        mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a;
   logic [1:0]  alu_src_b, alu_op;
   logic        reg_write, mem_to_reg, instr_done, illegal;
   logic [31:0] retired_count;

   logic        s_mem_read, s_mem_write, s_i_or_d, s_ir_write, s_pc_en, s_pc_source, s_alu_src_a;
   logic [1:0]  s_alu_src_b, s_alu_op;
   logic        s_reg_write, s_mem_to_reg, s_instr_done, s_illegal;
   logic [1:0]  s_retired_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_count = 32'd0;

   wire [13:0] outv = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                       alu_src_b, alu_op, reg_write, mem_to_reg, instr_done};

   multicycle_control #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode_i(opcode), .alu_zero_i(alu_zero), .mem_ready_i(mem_ready),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .i_or_d_o(i_or_d), .ir_write_o(ir_write),
      .pc_en_o(pc_en), .pc_source_o(pc_source), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_op_o(alu_op), .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
      .instr_done_o(instr_done), .retired_count_o(retired_count), .illegal_o(illegal)
   );

   multicycle_control #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .opcode_i(opcode), .alu_zero_i(alu_zero), .mem_ready_i(mem_ready),
      .mem_read_o(s_mem_read), .mem_write_o(s_mem_write), .i_or_d_o(s_i_or_d), .ir_write_o(s_ir_write),
      .pc_en_o(s_pc_en), .pc_source_o(s_pc_source), .alu_src_a_o(s_alu_src_a), .alu_src_b_o(s_alu_src_b),
      .alu_op_o(s_alu_op), .reg_write_o(s_reg_write), .mem_to_reg_o(s_mem_to_reg),
      .instr_done_o(s_instr_done), .retired_count_o(s_retired_count), .illegal_o(s_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst       = 1'b1;
      mem_ready = 1'b1;
      alu_zero  = 1'b1;
      opcode    = OP_ILL;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (outv !== V_ZERO) begin errors++; $display("FAIL reset_outputs: got %b expected %b", outv, V_ZERO); end
      checks++;
      if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", retired_count); end
      checks++;
      if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
      @(posedge clk); #1;
      rst       = 1'b0;
      exp_count = 32'd0;
      @(negedge clk);
      checks++;
      if (outv !== V_ZERO) begin errors++; $display("FAIL reset_idle_cycle: got %b expected %b", outv, V_ZERO); end
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      logic [13:0] exp [5] = '{V_FETCH_R, V_DECODE, V_MADDR, V_MRD, V_MWB};
      opcode    = OP_LW;
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) opcode = OP_SW;   // must be ignored after DECODE
         @(negedge clk);
         checks++;
         if (outv !== exp[i]) begin errors++; $display("FAIL lw_cycle%0d: got %b expected %b", i, outv, exp[i]); end
         @(posedge clk); #1;
      end
      exp_count = exp_count + 32'd1;
      checks++;
      if (retired_count !== exp_count) begin errors++; $display("FAIL lw_count: got %0d expected %0d", retired_count, exp_count); end
   endtask

   task automatic test_rtype();
      logic [13:0] exp [4] = '{V_FETCH_R, V_DECODE, V_EXEC, V_AWB};
      opcode    = OP_RTYP;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== exp[i]) begin errors++; $display("FAIL rtype_cycle%0d: got %b expected %b", i, outv, exp[i]); end
         @(posedge clk); #1;
      end
      exp_count = exp_count + 32'd1;
      checks++;
      if (retired_count !== exp_count) begin errors++; $display("FAIL rtype_count: got %0d expected %0d", retired_count, exp_count); end
   endtask

   task automatic test_beq();
      logic [13:0] exp1 [3] = '{V_FETCH_R, V_DECODE, V_BR_Z1};
      logic [13:0] exp0 [3] = '{V_FETCH_R, V_DECODE, V_BR_Z0};
      opcode    = OP_BEQ;
      mem_ready = 1'b1;
      alu_zero  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== exp1[i]) begin errors++; $display("FAIL beq_taken_cycle%0d: got %b expected %b", i, outv, exp1[i]); end
         @(posedge clk); #1;
      end
      alu_zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== exp0[i]) begin errors++; $display("FAIL beq_nottaken_cycle%0d: got %b expected %b", i, outv, exp0[i]); end
         @(posedge clk); #1;
      end
      exp_count = exp_count + 32'd2;
      checks++;
      if (retired_count !== exp_count) begin errors++; $display("FAIL beq_count: got %0d expected %0d", retired_count, exp_count); end
   endtask

   task automatic test_sw_stall();
      logic [13:0] exp [9] = '{V_FETCH_W, V_FETCH_W, V_FETCH_W, V_FETCH_R, V_DECODE, V_MADDR,
                               V_MWR_W, V_MWR_W, V_MWR_R};
      logic        rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int          n_pc = 0;
      int          n_ir = 0;
      int          n_done = 0;
      opcode = OP_SW;
      for (int i = 0; i < 9; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (outv !== exp[i]) begin errors++; $display("FAIL sw_stall_cycle%0d: got %b expected %b", i, outv, exp[i]); end
         if (pc_en === 1'b1) n_pc++;
         if (ir_write === 1'b1) n_ir++;
         if (instr_done === 1'b1) n_done++;
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      checks++;
      if (n_pc != 1) begin errors++; $display("FAIL sw_pc_en_pulses: got %0d expected 1", n_pc); end
      checks++;
      if (n_ir != 1) begin errors++; $display("FAIL sw_ir_write_pulses: got %0d expected 1", n_ir); end
      checks++;
      if (n_done != 1) begin errors++; $display("FAIL sw_done_pulses: got %0d expected 1", n_done); end
      exp_count = exp_count + 32'd1;
      checks++;
      if (retired_count !== exp_count) begin errors++; $display("FAIL sw_count: got %0d expected %0d", retired_count, exp_count); end
      checks++;
      if (s_retired_count !== exp_count[1:0]) begin errors++; $display("FAIL small_count_wrap: got %0d expected %0d", s_retired_count, exp_count[1:0]); end
   endtask

   task automatic test_illegal();
      opcode    = OP_ILL;
      mem_ready = 1'b1;
      checks++;
      if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_before: got %b expected 0", illegal); end
      @(negedge clk);
      checks++;
      if (outv !== V_FETCH_R) begin errors++; $display("FAIL illegal_fetch: got %b expected %b", outv, V_FETCH_R); end
      @(posedge clk); #1;
      @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
      checks++;
      if (outv !== V_DECODE) begin errors++; $display("FAIL illegal_decode: got %b expected %b", outv, V_DECODE); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== V_ZERO || illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_halt%0d: got %b/%b expected %b/1", i, outv, illegal, V_ZERO);
         end
         @(posedge clk); #1;
      end
`else
      checks++;
      if (outv !== V_DEC_ILL) begin errors++; $display("FAIL illegal_decode: got %b expected %b", outv, V_DEC_ILL); end
      @(posedge clk); #1;
      exp_count = exp_count + 32'd1;
      @(negedge clk);
      checks++;
      if (outv !== V_FETCH_R) begin errors++; $display("FAIL illegal_next_fetch: got %b expected %b", outv, V_FETCH_R); end
      checks++;
      if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", illegal); end
      checks++;
      if (retired_count !== exp_count) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", retired_count, exp_count); end
      checks++;
      if (s_retired_count !== exp_count[1:0]) begin errors++; $display("FAIL illegal_small_count: got %0d expected %0d", s_retired_count, exp_count[1:0]); end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset_midstall();
      logic [13:0] exp [5] = '{V_FETCH_R, V_DECODE, V_MADDR, V_MRD, V_MRD};
      logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      exp_count = 32'd0;
      checks++;
      if (illegal !== 1'b0 || retired_count !== 32'd0) begin
         errors++; $display("FAIL rerst_clear: got illegal=%b count=%0d expected 0/0", illegal, retired_count);
      end
      @(negedge clk);
      @(posedge clk); #1;
      opcode = OP_LW;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         if (i == 4) rst = 1'b1;
         @(negedge clk);
         checks++;
         if (outv !== exp[i]) begin errors++; $display("FAIL midstall_cycle%0d: got %b expected %b", i, outv, exp[i]); end
         @(posedge clk); #1;
      end
      rst       = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outv !== V_ZERO) begin errors++; $display("FAIL midstall_drop: got %b expected %b", outv, V_ZERO); end
      checks++;
      if (retired_count !== 32'd0) begin errors++; $display("FAIL midstall_count: got %0d expected 0", retired_count); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outv !== V_FETCH_R) begin errors++; $display("FAIL midstall_restart: got %b expected %b", outv, V_FETCH_R); end
      @(posedge clk); #1;
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 7'd0;
      alu_zero  = 1'b0;
      mem_ready = 1'b0;
      test_reset();
      test_lw();
      test_rtype();
      test_beq();
      test_sw_stall();
      test_illegal();
      test_reset_midstall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
